// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Optional feature macro: SEQ_PATTERN_TX_PARITY_EN (adds an even-parity bit per frame).
package seq_tx_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;

  // Level driven on the serial line whenever no frame is being sent.
  localparam logic IDLE_VAL_DEF = 1'b0;

  // Number of line cycles one frame occupies.
  function automatic int frame_len(input int pat_bits);
`ifdef SEQ_PATTERN_TX_PARITY_EN
    return pat_bits + 1;
`else
    return pat_bits;
`endif
  endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// Parameterised parallel-to-serial shift register, MSB first.
// Shifting is circular so a captured word can be replayed for repeated frames
// without reloading it.
module flex_pts_sr #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [NUM_BITS-1:0] data_i,
  output logic                msb_o
);

  logic [NUM_BITS-1:0] data_q;
  logic [NUM_BITS-1:0] data_d;

  // Load has priority over shift; shift rotates the MSB back into the LSB.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = {data_q[NUM_BITS-2:0], data_q[NUM_BITS-1]};
    end
  end

  // Storage register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_o = data_q[NUM_BITS-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a pattern and repeat count on start,
// then sends the pattern MSB-first repeat_cnt+1 times, followed by a done pulse.
// Optional feature macro: SEQ_PATTERN_TX_PARITY_EN (even-parity bit after each frame).
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int   PAT_BITS = 4,
  parameter int   CNT_BITS = 4,
  parameter logic IDLE_VAL = IDLE_VAL_DEF
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [PAT_BITS-1:0] pattern,
  input  logic [CNT_BITS-1:0] repeat_cnt,
  output logic                o,
  output logic                busy,
  output logic                done
);

  localparam int FRAME_LEN = frame_len(PAT_BITS);
  localparam int IDX_W     = $clog2(FRAME_LEN);

  tx_state_t           state_q, state_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [CNT_BITS-1:0] rep_q, rep_d;
  logic                o_q, o_d;
  logic                done_q, done_d;
  logic                sr_load;
  logic                sr_shift;
  logic                sr_msb;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  // The MSB goes straight to o on the accept edge, so the register is loaded
  // pre-rotated: its MSB is always the bit to send on the next advance.
  flex_pts_sr #(
    .NUM_BITS(PAT_BITS)
  ) u_sr (
    .clk    (clk),
    .n_rst  (n_rst),
    .load_i (sr_load),
    .shift_i(sr_shift),
    .data_i ({pattern[PAT_BITS-2:0], pattern[PAT_BITS-1]}),
    .msb_o  (sr_msb)
  );

  // Next-state, counter and output logic; bit_idx counts bits left in the frame.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    rep_d     = rep_q;
    o_d       = o_q;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        o_d = IDLE_VAL;
        if (start) begin
          state_d   = SEND;
          bit_idx_d = IDX_W'(FRAME_LEN - 1);
          rep_d     = repeat_cnt;
          o_d       = pattern[PAT_BITS-1];
          sr_load   = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
          par_d     = ^pattern;
`endif
        end
      end
      SEND: begin
        if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
`ifdef SEQ_PATTERN_TX_PARITY_EN
          // Last slot of a frame carries parity; the shifter stays put so the
          // next frame starts from the captured MSB.
          if (bit_idx_q == IDX_W'(1)) begin
            o_d = par_q;
          end else begin
            o_d      = sr_msb;
            sr_shift = 1'b1;
          end
`else
          o_d      = sr_msb;
          sr_shift = 1'b1;
`endif
        end else if (rep_q != '0) begin
          rep_d     = rep_q - CNT_BITS'(1);
          bit_idx_d = IDX_W'(FRAME_LEN - 1);
          o_d       = sr_msb;
          sr_shift  = 1'b1;
        end else begin
          state_d = DONE;
          o_d     = IDLE_VAL;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        o_d     = IDLE_VAL;
      end
      default: begin
        state_d = IDLE;
        o_d     = IDLE_VAL;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      rep_q     <= '0;
      o_q       <= IDLE_VAL;
      done_q    <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      rep_q     <= rep_d;
      o_q       <= o_d;
      done_q    <= done_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign o    = o_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a bit-stream model.
// Optional feature macro: SEQ_PATTERN_TX_PARITY_EN.
module tb_seq_pattern_tx;

  localparam int PAT_BITS = 4;
  localparam int CNT_BITS = 4;

  logic                clk = 1'b0;
  logic                n_rst = 1'b0;
  logic                start = 1'b0;
  logic [PAT_BITS-1:0] pattern = '0;
  logic [CNT_BITS-1:0] repeat_cnt = '0;
  logic                o;
  logic                busy;
  logic                done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .PAT_BITS(PAT_BITS),
    .CNT_BITS(CNT_BITS),
    .IDLE_VAL(1'b0)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .pattern   (pattern),
    .repeat_cnt(repeat_cnt),
    .o         (o),
    .busy      (busy),
    .done      (done)
  );

  // Reference model: the whole transfer is expanded into a queue of line bits
  // at acceptance; phase 0 = idle, 1 = streaming, 2 = completion cycle.
  logic exp_bits[$];
  int   m_phase = 0;
  logic exp_o = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s,
                            input logic [PAT_BITS-1:0] p, input logic [CNT_BITS-1:0] c);
    if (!r) begin
      exp_bits.delete();
      m_phase  = 0;
      exp_o    = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else if (m_phase == 0) begin
      exp_o    = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (s) begin
        for (int f = 0; f <= int'(c); f++) begin
          for (int b = PAT_BITS - 1; b >= 0; b--) exp_bits.push_back(p[b]);
`ifdef SEQ_PATTERN_TX_PARITY_EN
          exp_bits.push_back(^p);
`endif
        end
        $display("[TB] accept pattern=%b repeat_cnt=%0d bits=%0d t=%0t", p, c, exp_bits.size(), $time);
        m_phase  = 1;
        exp_o    = exp_bits.pop_front();
        exp_busy = 1'b1;
      end
    end else if (m_phase == 1) begin
      exp_busy = 1'b1;
      if (exp_bits.size() > 0) begin
        exp_o    = exp_bits.pop_front();
        exp_done = 1'b0;
      end else begin
        m_phase  = 2;
        exp_o    = 1'b0;
        exp_done = 1'b1;
      end
    end else begin
      m_phase  = 0;
      exp_o    = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, compare 1 time unit later.
  task automatic tick(input logic r, input logic s,
                      input logic [PAT_BITS-1:0] p, input logic [CNT_BITS-1:0] c);
    @(negedge clk);
    n_rst      = r;
    start      = s;
    pattern    = p;
    repeat_cnt = c;
    @(posedge clk);
    model_step(r, s, p, c);
    #1;
    check_eq("o", 32'(o), 32'(exp_o));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("done", 32'(done), 32'(exp_done));
  endtask

  initial begin
    // Reset held with start asserted, then released with start low.
    repeat (2) tick(1'b0, 1'b1, 4'b1111, 4'd3);
    repeat (2) tick(1'b1, 1'b0, 4'b0000, 4'd0);

    // Single frame.
    tick(1'b1, 1'b1, 4'b1101, 4'd0);
    repeat (7) tick(1'b1, 1'b0, 4'b0000, 4'd0);

    // Three contiguous frames.
    tick(1'b1, 1'b1, 4'b1011, 4'd2);
    repeat (16) tick(1'b1, 1'b0, 4'b0000, 4'd0);

    // Start during busy is ignored; held start re-accepts after DONE.
    tick(1'b1, 1'b1, 4'b1000, 4'd0);
    tick(1'b1, 1'b0, 4'b1000, 4'd0);
    repeat (12) tick(1'b1, 1'b1, 4'b0111, 4'd0);
    repeat (4) tick(1'b1, 1'b0, 4'b0000, 4'd0);

    // Reset in the middle of a repeated transfer, then a fresh transfer.
    tick(1'b1, 1'b1, 4'b1010, 4'd3);
    repeat (2) tick(1'b1, 1'b0, 4'b0000, 4'd0);
    tick(1'b0, 1'b0, 4'b0000, 4'd0);
    repeat (3) tick(1'b1, 1'b0, 4'b0000, 4'd0);
    tick(1'b1, 1'b1, 4'b1001, 4'd0);
    repeat (8) tick(1'b1, 1'b0, 4'b0000, 4'd0);

    // Maximum repeat count: 16 frames, no wrap.
    tick(1'b1, 1'b1, 4'b1001, 4'd15);
    repeat (90) tick(1'b1, 1'b0, 4'b0110, 4'd7);

    // Randomized traffic with occasional resets and pattern churn.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 60) != 0),
           ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15) < 12 ? $urandom_range(0, 3) : $urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
